// File: rtl/fetch_queue.sv
// fetch_queue
//   Decoupled instruction-fetch front end. Issues in-order fetch requests to a
//   variable-latency instruction memory and buffers the returned words in a
//   DEPTH-entry prefetch queue. Decode consumes the queue through a valid/ready
//   handshake. A redirect flushes the queue, reloads the fetch PC and marks all
//   in-flight responses as stale so they are dropped when they come back.
//
// Ports
//   clk_i, rst_ni         clock and synchronous active-low reset
//   pc_init_i             fetch PC loaded while reset is asserted
//   redirect_i            flush and refetch from redirect_pc_i (word aligned)
//   imem_req_valid_o      fetch request valid, address on imem_req_addr_o
//   imem_req_ready_i      memory accepts the request
//   imem_rsp_valid_i      in-order response valid, data on imem_rsp_data_i
//   valid_o / ready_i     head-of-queue handshake towards decode
//   instr_o, pc_o         head instruction and its PC
//   pc_next_4_o           head PC + 4 (modulo 2^XLEN)

module fetch_queue #(
  parameter int XLEN     = 32,
  parameter int DEPTH    = 4,
  parameter int MAX_OUTS = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [XLEN-1:0] pc_init_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_valid_o,
  input  logic            imem_req_ready_i,
  output logic [XLEN-1:0] imem_req_addr_o,
  input  logic            imem_rsp_valid_i,
  input  logic [31:0]     imem_rsp_data_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [31:0]     instr_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_next_4_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int OW = $clog2(MAX_OUTS) + 1;
  localparam int TW = (MAX_OUTS > 1) ? $clog2(MAX_OUTS) : 1;

  // Architectural state
  logic [XLEN-1:0] fetch_pc;
  logic [AW-1:0]   head;
  logic [AW-1:0]   tail;
  logic [CW-1:0]   count;
  logic [OW-1:0]   outs;
  logic [OW-1:0]   discard;
  logic [TW-1:0]   tag_wr;
  logic [TW-1:0]   tag_rd;

  // Storage (no reset needed, outputs are gated by valid_o)
  logic [31:0]     instr_mem [DEPTH];
  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [XLEN-1:0] pc4_mem   [DEPTH];
  logic [XLEN-1:0] tag_mem   [MAX_OUTS];

  logic            credit_ok;
  logic            req_fire;
  logic            deq;
  logic            enq;
  logic [OW-1:0]   outs_next;
  logic [XLEN-1:0] rsp_pc;

  // The two low bits of the redirect target are always cleared.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc_i[1:0];

  // Tag FIFO pointer advance; MAX_OUTS need not be a power of two.
  function automatic logic [TW-1:0] tag_inc(input logic [TW-1:0] p);
    return (p == TW'(MAX_OUTS - 1)) ? '0 : p + TW'(1);
  endfunction

  // Handshake decode. A request is only issued when the queue has room for
  // every in-flight response plus this one, so enqueue can never overflow.
  // Responses arriving while stale ones are pending, or in a redirect cycle,
  // are dropped.
  always_comb begin
    credit_ok        = (32'(count) + 32'(outs) < 32'(DEPTH)) &&
                       (32'(outs) < 32'(MAX_OUTS));
    imem_req_valid_o = rst_ni && !redirect_i && credit_ok;
    req_fire         = imem_req_valid_o && imem_req_ready_i;
    valid_o          = rst_ni && (count != '0);
    deq              = valid_o && ready_i;
    enq              = imem_rsp_valid_i && !redirect_i && (discard == '0);
    outs_next        = outs + OW'(req_fire) - OW'(imem_rsp_valid_i);
    rsp_pc           = tag_mem[tag_rd];
  end

  assign imem_req_addr_o = fetch_pc;

  // Head outputs come straight from registered storage and read zero when
  // the queue is empty.
  always_comb begin
    instr_o     = '0;
    pc_o        = '0;
    pc_next_4_o = '0;
    if (valid_o) begin
      instr_o     = instr_mem[head];
      pc_o        = pc_mem[head];
      pc_next_4_o = pc4_mem[head];
    end
  end

  // Control state. Redirect wins over everything: the queue empties and all
  // requests still in flight after this cycle become stale. The tag FIFO keeps
  // running because stale responses still consume their tags in order.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      fetch_pc <= pc_init_i;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      outs     <= '0;
      discard  <= '0;
      tag_wr   <= '0;
      tag_rd   <= '0;
    end else begin
      outs <= outs_next;
      if (req_fire) begin
        tag_wr <= tag_inc(tag_wr);
      end
      if (imem_rsp_valid_i) begin
        tag_rd <= tag_inc(tag_rd);
      end
      if (redirect_i) begin
        fetch_pc <= {redirect_pc_i[XLEN-1:2], 2'b00};
        discard  <= outs_next;
        head     <= '0;
        tail     <= '0;
        count    <= '0;
      end else begin
        if (req_fire) begin
          fetch_pc <= fetch_pc + XLEN'(4);
        end
        if (imem_rsp_valid_i && (discard != '0)) begin
          discard <= discard - OW'(1);
        end
        if (enq) begin
          tail <= tail + AW'(1);
        end
        if (deq) begin
          head <= head + AW'(1);
        end
        count <= count + CW'(enq) - CW'(deq);
      end
    end
  end

  // Data storage for the queue and the request-PC tag FIFO.
  always_ff @(posedge clk_i) begin
    if (enq) begin
      instr_mem[tail] <= imem_rsp_data_i;
      pc_mem[tail]    <= rsp_pc;
      pc4_mem[tail]   <= rsp_pc + XLEN'(4);
    end
    if (req_fire) begin
      tag_mem[tag_wr] <= fetch_pc;
    end
  end

  // Occupancy and in-flight counters must stay within their bounds, and a
  // response must always match an outstanding request.
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      assert (count <= CW'(DEPTH));
      assert (outs <= OW'(MAX_OUTS));
      assert (!imem_rsp_valid_i || (outs != '0));
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue
//   Drives fetch_queue with directed scenarios against an in-order
//   variable-latency memory model, and checks every cycle against a
//   queue-level reference model plus hand-computed literal expectations.

module tb_fetch_queue;

  localparam int XLEN     = 32;
  localparam int DEPTH    = 4;
  localparam int MAX_OUTS = 2;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic [XLEN-1:0]   pc_init_i;
  logic              redirect_i;
  logic [XLEN-1:0]   redirect_pc_i;
  logic              imem_req_valid_o;
  logic              imem_req_ready_i;
  logic [XLEN-1:0]   imem_req_addr_o;
  logic              imem_rsp_valid_i;
  logic [31:0]       imem_rsp_data_i;
  logic              valid_o;
  logic              ready_i;
  logic [31:0]       instr_o;
  logic [XLEN-1:0]   pc_o;
  logic [XLEN-1:0]   pc_next_4_o;

  always #5 clk_i = ~clk_i;

  fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .MAX_OUTS(MAX_OUTS)) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .pc_init_i        (pc_init_i),
    .redirect_i       (redirect_i),
    .redirect_pc_i    (redirect_pc_i),
    .imem_req_valid_o (imem_req_valid_o),
    .imem_req_ready_i (imem_req_ready_i),
    .imem_req_addr_o  (imem_req_addr_o),
    .imem_rsp_valid_i (imem_rsp_valid_i),
    .imem_rsp_data_i  (imem_rsp_data_i),
    .valid_o          (valid_o),
    .ready_i          (ready_i),
    .instr_o          (instr_o),
    .pc_o             (pc_o),
    .pc_next_4_o      (pc_next_4_o)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int mem_lat = 1;

  // Memory model: accepted requests come back mem_lat cycles later, in order.
  typedef struct { int due; logic [31:0] addr; } mreq_t;
  mreq_t mem_q[$];

  // Reference model: the queue contents, and the in-flight requests with a
  // stale flag set by redirect.
  typedef struct { logic [31:0] instr; logic [31:0] pc; } ent_t;
  typedef struct { logic [31:0] pc; bit stale; } fly_t;
  ent_t        ref_q[$];
  fly_t        fly_q[$];
  logic [31:0] ref_pc = '0;

  // Log of entries taken by decode, and the last sampled outputs.
  logic [31:0] pop_pc[$];
  logic [31:0] pop_pc4[$];
  int          pop_cyc[$];
  logic        s_valid, s_reqv;
  logic [31:0] s_addr, s_pc, s_instr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_0013;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%h, expected 0x%h", name, cyc, act, exp);
    end
  endtask

  task automatic checkPopPc(input string name, input int idx, input logic [31:0] exp);
    if (idx >= pop_pc.size()) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: only %0d entries popped, expected entry %0d = 0x%h", name, pop_pc.size(), idx, exp);
    end else begin
      checkOutput(name, pop_pc[idx], exp);
    end
  endtask

  task automatic checkPopPc4(input string name, input int idx, input logic [31:0] exp);
    if (idx >= pop_pc4.size()) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: only %0d entries popped, expected entry %0d = 0x%h", name, pop_pc4.size(), idx, exp);
    end else begin
      checkOutput(name, pop_pc4[idx], exp);
    end
  endtask

  task automatic checkPopCyc(input string name, input int idx, input int exp);
    if (idx >= pop_cyc.size()) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: only %0d entries popped, expected pop %0d at cycle %0d", name, pop_cyc.size(), idx, exp);
    end else begin
      checkOutput(name, 32'(pop_cyc[idx]), 32'(exp));
    end
  endtask

  task automatic clearLog();
    pop_pc.delete();
    pop_pc4.delete();
    pop_cyc.delete();
  endtask

  // One clock cycle: drive inputs after the falling edge, compare outputs
  // against the reference model, then advance both models at the rising edge.
  task automatic applyStimulus(input logic rst, input logic redir, input logic [31:0] rpc,
                               input logic rdy, input logic mrdy);
    logic        exp_valid, exp_rv, fire, rsp, deq;
    logic [31:0] addr;
    ent_t        e;
    fly_t        f;
    rst_ni           = rst;
    redirect_i       = redir;
    redirect_pc_i    = rpc;
    ready_i          = rdy;
    imem_req_ready_i = mrdy;
    if (rst && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_rsp_valid_i = 1'b1;
      imem_rsp_data_i  = mem_word(mem_q[0].addr);
    end else begin
      imem_rsp_valid_i = 1'b0;
      imem_rsp_data_i  = '0;
    end
    #1;
    exp_valid = rst && (ref_q.size() > 0);
    exp_rv    = rst && !redir && (ref_q.size() + fly_q.size() < DEPTH) && (fly_q.size() < MAX_OUTS);
    checkOutput("valid_o", 32'(valid_o), 32'(exp_valid));
    checkOutput("imem_req_valid_o", 32'(imem_req_valid_o), 32'(exp_rv));
    if (exp_rv) checkOutput("imem_req_addr_o", imem_req_addr_o, ref_pc);
    if (exp_valid) begin
      e = ref_q[0];
      checkOutput("instr_o", instr_o, e.instr);
      checkOutput("pc_o", pc_o, e.pc);
      checkOutput("pc_next_4_o", pc_next_4_o, e.pc + 32'd4);
    end else begin
      checkOutput("instr_o_idle", instr_o, 32'h0);
      checkOutput("pc_o_idle", pc_o, 32'h0);
      checkOutput("pc_next_4_o_idle", pc_next_4_o, 32'h0);
    end
    s_valid = valid_o;
    s_reqv  = imem_req_valid_o;
    s_addr  = imem_req_addr_o;
    s_pc    = pc_o;
    s_instr = instr_o;
    if (valid_o && ready_i) begin
      pop_pc.push_back(pc_o);
      pop_pc4.push_back(pc_next_4_o);
      pop_cyc.push_back(cyc);
    end
    fire = imem_req_valid_o && mrdy;
    addr = imem_req_addr_o;
    rsp  = imem_rsp_valid_i;
    deq  = exp_valid && rdy;
    @(posedge clk_i);
    if (!rst) begin
      ref_pc = pc_init_i;
      ref_q.delete();
      fly_q.delete();
      mem_q.delete();
      cyc = 0;
    end else begin
      if (rsp) void'(mem_q.pop_front());
      if (fire) mem_q.push_back('{cyc + mem_lat, addr});
      if (deq) void'(ref_q.pop_front());
      if (rsp && fly_q.size() > 0) begin
        f = fly_q.pop_front();
        if (!f.stale && !redir) ref_q.push_back('{mem_word(f.pc), f.pc});
      end
      if (redir) begin
        ref_q.delete();
        foreach (fly_q[i]) fly_q[i].stale = 1'b1;
        ref_pc = {rpc[31:2], 2'b00};
      end else if (exp_rv && mrdy) begin
        fly_q.push_back('{ref_pc, 1'b0});
        ref_pc = ref_pc + 32'd4;
      end
      cyc++;
    end
    @(negedge clk_i);
  endtask

  task automatic runCycles(input int n, input logic rdy, input logic mrdy);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 32'h0, rdy, mrdy);
  endtask

  task automatic doReset(input logic [31:0] init, input int lat);
    pc_init_i = init;
    mem_lat   = lat;
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    clearLog();
  endtask

  initial begin
    rst_ni           = 1'b0;
    pc_init_i        = '0;
    redirect_i       = 1'b0;
    redirect_pc_i    = '0;
    imem_req_ready_i = 1'b0;
    imem_rsp_valid_i = 1'b0;
    imem_rsp_data_i  = '0;
    ready_i          = 1'b0;

    // Basic streaming, 1-cycle memory, then memory back-pressure.
    doReset(32'h0000_1000, 1);
    runCycles(6, 1'b1, 1'b1);
    checkPopCyc("s1_first_valid_cycle", 0, 2);
    checkPopCyc("s1_second_valid_cycle", 1, 3);
    checkPopPc("s1_pc0", 0, 32'h0000_1000);
    checkPopPc("s1_pc1", 1, 32'h0000_1004);
    checkPopPc("s1_pc2", 2, 32'h0000_1008);
    checkPopPc4("s1_pc4_1", 1, 32'h0000_1008);
    runCycles(3, 1'b1, 1'b0);
    runCycles(4, 1'b1, 1'b1);

    // PC wrap-around.
    doReset(32'hFFFF_FFF8, 1);
    runCycles(6, 1'b1, 1'b1);
    checkPopPc("s5_pc0", 0, 32'hFFFF_FFF8);
    checkPopPc("s5_pc1", 1, 32'hFFFF_FFFC);
    checkPopPc("s5_pc2", 2, 32'h0000_0000);
    checkPopPc4("s5_pc4_1", 1, 32'h0000_0000);
    checkPopPc4("s5_pc4_2", 2, 32'h0000_0004);

    // Fill with decode stalled, then drain in order.
    doReset(32'h0000_3000, 1);
    runCycles(8, 1'b0, 1'b1);
    checkOutput("s2_full_req_valid", 32'(s_reqv), 32'h0);
    checkOutput("s2_full_valid", 32'(s_valid), 32'h1);
    runCycles(8, 1'b1, 1'b1);
    checkPopPc("s2_pc0", 0, 32'h0000_3000);
    checkPopPc("s2_pc1", 1, 32'h0000_3004);
    checkPopPc("s2_pc2", 2, 32'h0000_3008);
    checkPopPc("s2_pc3", 3, 32'h0000_300C);
    checkPopPc("s2_pc4", 4, 32'h0000_3010);

    // Reset mid-stream with a full queue.
    runCycles(8, 1'b0, 1'b1);
    pc_init_i = 32'h0000_7000;
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("s6_rst_req_valid", 32'(s_reqv), 32'h0);
    checkOutput("s6_rst_valid", 32'(s_valid), 32'h0);
    clearLog();
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    checkOutput("s6_post_valid", 32'(s_valid), 32'h0);
    checkOutput("s6_post_pc", s_pc, 32'h0);
    checkOutput("s6_post_instr", s_instr, 32'h0);
    checkOutput("s6_post_addr", s_addr, 32'h0000_7000);
    runCycles(5, 1'b1, 1'b1);
    checkPopPc("s6_refetch_pc0", 0, 32'h0000_7000);

    // Redirect with two stale responses in flight, 3-cycle memory.
    doReset(32'h0000_1000, 3);
    runCycles(2, 1'b1, 1'b1);
    clearLog();
    applyStimulus(1'b1, 1'b1, 32'h0000_2002, 1'b1, 1'b1);
    runCycles(12, 1'b1, 1'b1);
    checkPopPc("s3_first_new_pc", 0, 32'h0000_2000);
    checkPopPc("s3_second_new_pc", 1, 32'h0000_2004);
    checkPopCyc("s3_first_new_cycle", 0, 8);
    foreach (pop_pc[i]) checkOutput("s3_no_stale_pc", {12'h0, pop_pc[i][31:12]}, 32'h2);

    // Redirect coincident with a response and a dequeue, 2-cycle memory.
    doReset(32'h0000_4000, 2);
    runCycles(5, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 32'h0000_5000, 1'b1, 1'b1);
    checkPopPc("s4_redirect_deq_pc", 0, 32'h0000_4000);
    clearLog();
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    checkOutput("s4_empty_after_redirect", 32'(s_valid), 32'h0);
    runCycles(10, 1'b1, 1'b1);
    checkPopPc("s4_first_new_pc", 0, 32'h0000_5000);
    checkPopPc("s4_second_new_pc", 1, 32'h0000_5004);
    checkPopCyc("s4_first_new_cycle", 0, 9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
